macpu_bus_arbiter: RTL and testbench
====================================

# macpu_bus_arbiter

Parametrised external-bus interface unit for the MACPU core: arbitrates N internal bus masters (PC fetch, decoder, ALU, controller) onto one external memory/IO bus. It replaces fixed tristate steering with a registered round-robin grant, a ready-based wait-state handshake, multi-transfer bus locking and an optional transfer timeout. It sits between the core's internal requesters and the chip-level address/data/lock pins.

## Interface
- NUM_MASTERS, 4, number of requesters (2..8)
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT_CYC, 15, wait cycles before a transfer is aborted (used only with timeout enabled)
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- i_req  in  NUM_MASTERS  per-master transfer request; held until the matching o_done
- i_we  in  NUM_MASTERS  1 = write, 0 = read (0 = input/read, 1 = output/write)
- i_lock_req  in  NUM_MASTERS  owner keeps the bus across consecutive transfers
- i_addr  in  NUM_MASTERS*ADDR_W  packed addresses; master m occupies [m*ADDR_W +: ADDR_W]
- i_wdata  in  NUM_MASTERS*DATA_W  packed write data
- o_gnt  out  NUM_MASTERS  one-hot grant; high for XFER and DONE
- o_done  out  NUM_MASTERS  one-cycle completion pulse to the granted master
- o_err  out  1  pulses with o_done when a transfer timed out
- o_rdata  out  DATA_W  registered read data; valid while o_done is high
- o_rw  out  1  external direction: 1 = write
- o_addr  out  ADDR_W  external address
- o_wdata  out  DATA_W  external write data
- o_data_oe  out  1  external data driver enable; equals o_rw during XFER
- i_rdata  in  DATA_W  external read data
- i_ready  in  1  external slave completes the current transfer
- i_ext_lock  in  1  another bus agent holds the external lock
- o_bus_lock  out  1  this unit holds the external lock

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE: if i_ext_lock = 0 and any eligible request is present, select the winner by round-robin starting at `rr_ptr`, register its grant, address, data and we, then go to XFER. While a lock owner is recorded, only the owner is eligible.
- XFER: drive o_addr, o_wdata, o_rw and o_data_oe from the registered values.
  - On i_ready = 1: capture i_rdata into o_rdata and go to DONE.
  - With timeout enabled, wait cycles are counted. When the count reaches TIMEOUT_CYC with i_ready still low, set err and go to DONE.
- DONE: o_done[g] = 1 (and o_err = err) for one cycle, then go to IDLE.
  - If i_lock_req[g] = 1, the owner is recorded and o_bus_lock stays high.
  - Otherwise the lock is cleared and rr_ptr = g+1 mod NUM_MASTERS.
- Lock release: in IDLE, if the recorded owner's i_lock_req = 0, clear the owner and o_bus_lock and advance rr_ptr past the owner in the same cycle.
- o_bus_lock rises on entry to XFER and stays high while a lock owner is recorded.
- i_ext_lock rising during XFER does not abort the current transfer. It only blocks new grants from IDLE, unless this unit already holds the lock.
- Requests withdrawn before o_done have undefined results; the bench flags them as protocol errors.

## Timing
- Reset: state IDLE, rr_ptr = 0, no owner, counters 0. All outputs reset to 0: o_gnt, o_done, o_err, o_rdata, o_rw, o_addr, o_wdata, o_data_oe, o_bus_lock.
- Reset mid-transfer aborts with no o_done pulse.
- A request is sampled at edge k. o_gnt and the external bus are valid after edge k+1.
- If i_ready is already high in the first XFER cycle, o_done is high after edge k+2. Best-case latency is 2 cycles; each cycle of i_ready low adds 1 cycle.
- The wait counter is ADDR_W-independent and $clog2(TIMEOUT_CYC+1) bits wide. It saturates and is cleared on XFER entry.
- Back-to-back transfers: one IDLE cycle between DONE and the next XFER, so each master sees a minimum of 3 cycles per transfer.
- Simultaneous requests from all masters: grants rotate m0, m1, m2, m3, m0…

## Configuration
- `MACPU_BUS_TIMEOUT_EN` defined: the wait counter and abort path are present, and o_err is functional.
- Undefined: XFER waits indefinitely for i_ready, o_err is tied to 0, and TIMEOUT_CYC is ignored.

## Structure
- Shared package `macpu_pkg`:
  - state enum (IDLE/XFER/DONE)
  - direction constants RD = 0, WR = 1
  - default widths ADDR_W/DATA_W = 16
- Sub-module `macpu_rr_arbiter`: combinational round-robin one-hot picker.
  - Inputs: request vector and rr_ptr.
  - Outputs: one-hot grant and binary index.
  - The FSM, lock and timeout logic stay in the top.

## Test plan
- Single read: m1 reads 0x1234, i_ready high immediately, i_rdata = 0xBEEF -> o_gnt = 0010 after 1 cycle, o_done[1] after 2 cycles, o_rdata = 0xBEEF, o_rw = 0.
- All four masters requesting writes continuously -> grant order m0, m1, m2, m3, m0; each transfer drives its own o_addr/o_wdata with o_data_oe = 1.
- m2 holds i_lock_req for 3 writes while m0 also requests -> m2 wins 3 times consecutively with o_bus_lock = 1 throughout; m0 is granted right after release.
- i_ext_lock = 1 with m0 requesting -> no grant while high; grant 1 cycle after it falls.
- With MACPU_BUS_TIMEOUT_EN and TIMEOUT_CYC = 4, i_ready held low -> o_done[0] and o_err pulse after 4 wait cycles, then the FSM returns to IDLE.
- rst asserted during XFER with i_ready low -> next cycle all outputs 0, state IDLE, no o_done.

Source files
------------

// File: rtl/macpu_pkg.sv
// Shared types and constants for the MACPU external-bus interface unit.
package macpu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDone
  } state_e;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/macpu_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module macpu_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   vld
);

  always_comb begin
    int unsigned c;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c   = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      c = 32'(ptr) + i;
      if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
      if (!vld && req[c[IDX_W-1:0]]) begin
        vld                = 1'b1;
        gnt[c[IDX_W-1:0]]  = 1'b1;
        idx                = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/macpu_bus_arbiter.sv
// External-bus interface unit: round-robin grant, ready handshake, bus locking.
// Optional transfer timeout enabled by defining MACPU_BUS_TIMEOUT_EN.
module macpu_bus_arbiter
  import macpu_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        i_req,
  input  logic [NUM_MASTERS-1:0]        i_we,
  input  logic [NUM_MASTERS-1:0]        i_lock_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_wdata,
  output logic [NUM_MASTERS-1:0]        o_gnt,
  output logic [NUM_MASTERS-1:0]        o_done,
  output logic                          o_err,
  output logic [DATA_W-1:0]             o_rdata,
  output logic                          o_rw,
  output logic [ADDR_W-1:0]             o_addr,
  output logic [DATA_W-1:0]             o_wdata,
  output logic                          o_data_oe,
  input  logic [DATA_W-1:0]             i_rdata,
  input  logic                          i_ready,
  input  logic                          i_ext_lock,
  output logic                          o_bus_lock
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic                     owner_vld_q, owner_vld_d;
  logic                     bus_lock_q, bus_lock_d;
  logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]         gidx_q, gidx_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;

  logic                     owner_holds;
  logic [NUM_MASTERS-1:0]   owner_mask;
  logic [NUM_MASTERS-1:0]   elig;
  logic [IDX_W-1:0]         arb_ptr;
  logic [NUM_MASTERS-1:0]   pick_gnt;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_vld;

`ifdef MACPU_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;
`endif

  // A recorded owner that still asserts its lock request excludes everyone else.
  assign owner_holds = owner_vld_q && i_lock_req[owner_q];
  assign owner_mask  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;
  assign elig        = owner_holds ? (i_req & owner_mask) : i_req;
  assign arb_ptr     = (owner_vld_q && !owner_holds) ?
                       IDX_W'(wrap_inc(32'(owner_q), NUM_MASTERS)) : rr_ptr_q;

  macpu_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .req (elig),
    .ptr (arb_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    bus_lock_d  = bus_lock_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
`ifdef MACPU_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (owner_vld_q && !owner_holds) begin
          owner_vld_d = 1'b0;
          bus_lock_d  = 1'b0;
          rr_ptr_d    = arb_ptr;
        end
        if ((!i_ext_lock || owner_holds) && pick_vld) begin
          state_d    = StXfer;
          gnt_d      = pick_gnt;
          gidx_d     = pick_idx;
          addr_d     = i_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
          wdata_d    = i_wdata[32'(pick_idx) * DATA_W +: DATA_W];
          we_d       = i_we[pick_idx];
          bus_lock_d = 1'b1;
`ifdef MACPU_BUS_TIMEOUT_EN
          cnt_d      = '0;
          err_d      = 1'b0;
`endif
        end
      end
      StXfer: begin
        if (i_ready) begin
          rdata_d = i_rdata;
          state_d = StDone;
        end
`ifdef MACPU_BUS_TIMEOUT_EN
        else if (cnt_q >= CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        if (i_lock_req[gidx_q]) begin
          owner_vld_d = 1'b1;
          owner_d     = gidx_q;
        end else begin
          owner_vld_d = 1'b0;
          bus_lock_d  = 1'b0;
          rr_ptr_d    = IDX_W'(wrap_inc(32'(gidx_q), NUM_MASTERS));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      bus_lock_q  <= 1'b0;
      gnt_q       <= '0;
      gidx_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      bus_lock_q  <= bus_lock_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef MACPU_BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_err = (state_q == StDone) && err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_gnt      = gnt_q;
  assign o_done     = (state_q == StDone) ? gnt_q : '0;
  assign o_rdata    = rdata_q;
  assign o_rw       = we_q;
  assign o_addr     = addr_q;
  assign o_wdata    = wdata_q;
  assign o_data_oe  = (state_q == StXfer) && (we_q == WR);
  assign o_bus_lock = bus_lock_q;

endmodule

// File: tb/tb_macpu_bus_arbiter.sv
// Directed self-checking bench for macpu_bus_arbiter (timeout checks follow MACPU_BUS_TIMEOUT_EN).
module tb_macpu_bus_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    i_req, i_we, i_lock_req;
  logic [NM*AW-1:0] i_addr;
  logic [NM*DW-1:0] i_wdata;
  logic [NM-1:0]    o_gnt, o_done;
  logic             o_err, o_rw, o_data_oe, o_bus_lock;
  logic [DW-1:0]    o_rdata, o_wdata, i_rdata;
  logic [AW-1:0]    o_addr;
  logic             i_ready, i_ext_lock;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  macpu_bus_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_lock_req (i_lock_req),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_gnt      (o_gnt),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_rdata    (o_rdata),
    .o_rw       (o_rw),
    .o_addr     (o_addr),
    .o_wdata    (o_wdata),
    .o_data_oe  (o_data_oe),
    .i_rdata    (i_rdata),
    .i_ready    (i_ready),
    .i_ext_lock (i_ext_lock),
    .o_bus_lock (o_bus_lock)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (o_gnt == '0 && n < 8) begin
      tick();
      n++;
    end
    check("gnt_seen", 32'(o_gnt != '0), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(o_gnt),      32'(0));
    check({tag, "_done"},  32'(o_done),     32'(0));
    check({tag, "_err"},   32'(o_err),      32'(0));
    check({tag, "_rdata"}, 32'(o_rdata),    32'(0));
    check({tag, "_rw"},    32'(o_rw),       32'(0));
    check({tag, "_addr"},  32'(o_addr),     32'(0));
    check({tag, "_wdata"}, 32'(o_wdata),    32'(0));
    check({tag, "_oe"},    32'(o_data_oe),  32'(0));
    check({tag, "_lock"},  32'(o_bus_lock), 32'(0));
  endtask

  task automatic do_reset();
    i_req = '0; i_we = '0; i_lock_req = '0; i_addr = '0; i_wdata = '0;
    i_rdata = '0; i_ready = 1'b0; i_ext_lock = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [NM-1:0] exp_g;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    // Reset values
    do_reset();
    check_all_zero("reset");

    // Single read by m1
    i_req = 4'b0010; i_we = 4'b0000;
    i_addr[1*AW +: AW] = 16'h1234;
    i_ready = 1'b1; i_rdata = 16'hBEEF;
    tick();
    check("rd_gnt",  32'(o_gnt),      32'h2);
    check("rd_addr", 32'(o_addr),     32'h1234);
    check("rd_rw",   32'(o_rw),       32'(0));
    check("rd_oe",   32'(o_data_oe),  32'(0));
    check("rd_lock", 32'(o_bus_lock), 32'(1));
    check("rd_nodone", 32'(o_done),   32'(0));
    tick();
    check("rd_done",  32'(o_done),  32'h2);
    check("rd_rdata", 32'(o_rdata), 32'hBEEF);
    i_req = '0;
    tick();
    check("rd_idle_gnt",  32'(o_gnt),      32'(0));
    check("rd_idle_lock", 32'(o_bus_lock), 32'(0));

    // Round-robin over four continuous writers
    do_reset();
    for (int m = 0; m < 4; m++) begin
      i_addr[m*AW +: AW]  = 16'h1000 + 16'(m);
      i_wdata[m*DW +: DW] = 16'hA000 + 16'(m);
    end
    i_we = 4'b1111; i_req = 4'b1111; i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      check("rr_latency", 32'(n), 32'(1));
      exp_g = 4'b0001 << order[k];
      check("rr_gnt",   32'(o_gnt),     32'(exp_g));
      check("rr_addr",  32'(o_addr),    32'h1000 + 32'(order[k]));
      check("rr_wdata", 32'(o_wdata),   32'hA000 + 32'(order[k]));
      check("rr_oe",    32'(o_data_oe), 32'(1));
      check("rr_rw",    32'(o_rw),      32'(1));
      tick();
      check("rr_done",  32'(o_done),    32'(exp_g));
      tick();
    end

    // m2 locks for three writes while m0 waits
    do_reset();
    i_addr[2*AW +: AW] = 16'h2200; i_addr[0*AW +: AW] = 16'h0100;
    i_we = 4'b0101; i_ready = 1'b1;
    i_req = 4'b0100; i_lock_req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(n);
      if (k == 0) i_req = 4'b0101;
      else check("lk_latency", 32'(n), 32'(1));
      check("lk_gnt",  32'(o_gnt),      32'h4);
      check("lk_lock", 32'(o_bus_lock), 32'(1));
      tick();
      check("lk_done",      32'(o_done),     32'h4);
      check("lk_lock_done", 32'(o_bus_lock), 32'(1));
      if (k == 2) begin
        i_req = 4'b0001; i_lock_req = 4'b0000;
      end
      tick();
      if (k < 2) check("lk_lock_idle", 32'(o_bus_lock), 32'(1));
    end
    wait_gnt(n);
    check("lk_m0_latency", 32'(n),      32'(1));
    check("lk_m0_gnt",     32'(o_gnt),  32'h1);
    check("lk_m0_addr",    32'(o_addr), 32'h0100);
    tick();
    i_req = '0;
    tick();

    // External lock blocks grants; rising mid-transfer does not abort
    do_reset();
    i_ext_lock = 1'b1; i_req = 4'b0001; i_ready = 1'b0;
    tick(); tick(); tick();
    check("ext_blocked", 32'(o_gnt), 32'(0));
    i_ext_lock = 1'b0;
    tick();
    check("ext_gnt", 32'(o_gnt), 32'h1);
    i_ext_lock = 1'b1;
    tick();
    check("ext_hold_gnt",  32'(o_gnt),  32'h1);
    check("ext_hold_done", 32'(o_done), 32'(0));
    i_ready = 1'b1; i_rdata = 16'h0C0D;
    tick();
    check("ext_done",  32'(o_done),  32'h1);
    check("ext_rdata", 32'(o_rdata), 32'h0C0D);
    i_req = '0; i_ext_lock = 1'b0;
    tick();

    // Wait states: timeout abort or indefinite wait
    do_reset();
    i_req = 4'b0001; i_we = 4'b0000; i_ready = 1'b0;
    tick();
    check("to_gnt", 32'(o_gnt), 32'h1);
`ifdef MACPU_BUS_TIMEOUT_EN
    tick(); tick(); tick();
    check("to_wait_done", 32'(o_done), 32'(0));
    tick();
    check("to_done", 32'(o_done), 32'h1);
    check("to_err",  32'(o_err),  32'(1));
    i_req = '0;
    tick();
    check("to_idle_done", 32'(o_done), 32'(0));
    check("to_idle_err",  32'(o_err),  32'(0));
    check("to_idle_gnt",  32'(o_gnt),  32'(0));
`else
    for (int k = 0; k < 6; k++) tick();
    check("ws_wait_done", 32'(o_done), 32'(0));
    check("ws_wait_gnt",  32'(o_gnt),  32'h1);
    i_ready = 1'b1; i_rdata = 16'h5A5A;
    tick();
    check("ws_done",  32'(o_done),  32'h1);
    check("ws_err",   32'(o_err),   32'(0));
    check("ws_rdata", 32'(o_rdata), 32'h5A5A);
    i_req = '0;
    tick();
`endif

    // Reset mid-transfer
    do_reset();
    i_req = 4'b1000; i_we = 4'b1000; i_ready = 1'b0;
    i_addr[3*AW +: AW] = 16'h3333; i_wdata[3*DW +: DW] = 16'h7777;
    tick();
    check("mr_gnt", 32'(o_gnt),     32'h8);
    check("mr_oe",  32'(o_data_oe), 32'(1));
    rst = 1'b1;
    tick();
    check_all_zero("mr_rst");
    rst = 1'b0; i_req = '0;
    tick();
    tick();
    check("mr_after_done", 32'(o_done), 32'(0));
    check("mr_after_gnt",  32'(o_gnt),  32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
